mbgd_dot_prod_acc: RTL

MBGD_DOT_PROD_ACC -- requirements
Module: mbgd_dot_prod_acc

---
 rtl/mbgd_dot_prod_acc.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mbgd_dot_prod_acc.sv
// ---------------------------------------------------------------------------
// mbgd_dot_prod_acc
//   Streaming dot-product accumulator. Each accepted beat carries N lane pairs
//   (a, b). The beat is multiplied lane by lane, the N products are reduced by
//   an adder tree, and beat sums are accumulated until the beat marked last.
//   The whole-vector result is then presented on the output handshake.
//   Pipeline: multiply -> reduce -> accumulate. A last beat accepted in cycle
//   t gives out_valid_o in cycle t+3. The entire pipeline freezes while a
//   result is held unconsumed.
//
// Ports
//   clk             clock; all state updates on the rising edge
//   reset           synchronous, active-high reset
//   in_valid_i      beat valid
//   in_ready_o      beat accepted when in_valid_i && in_ready_o
//   in_a_i, in_b_i  N lanes of DW bits; lane k at [(k+1)*DW-1 : k*DW]
//   in_last_i       beat is the final beat of its vector
//   in_signed_i     lanes are two's complement (1) or unsigned (0)
//   out_valid_o     result valid
//   out_ready_i     result consumed when out_valid_o && out_ready_i
//   out_data_o      vector dot product, AW bits, wraps modulo 2^AW
//   out_beats_o     beat count of the reported vector (saturates)
//   err_overflow_o  sticky: beat-count overflow or signedness mismatch
// ---------------------------------------------------------------------------
module mbgd_dot_prod_acc #(
  parameter  int N         = 8,
  parameter  int DW        = 8,
  parameter  int MAX_BEATS = 16,
  localparam int PW        = 2 * DW,
  localparam int TW        = PW + $clog2(N),
  localparam int BW        = $clog2(MAX_BEATS) + 1,
  localparam int AW        = TW + BW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [DW*N-1:0] in_a_i,
  input  logic [DW*N-1:0] in_b_i,
  input  logic            in_last_i,
  input  logic            in_signed_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [AW-1:0]   out_data_o,
  output logic [BW-1:0]   out_beats_o,
  output logic            err_overflow_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_e;

  localparam logic [BW-1:0] CNT_ONE = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] CNT_MAX = BW'(MAX_BEATS);

  // Operands are extended to PW bits first, so the PW-bit truncated product
  // is exact for both the signed and the unsigned interpretation.
  function automatic logic [PW-1:0] lane_mul(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input logic          sgn);
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    ea = sgn ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    eb = sgn ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [TW-1:0] prod_ext(input logic [PW-1:0] p,
                                             input logic          sgn);
    return sgn ? {{(TW-PW){p[PW-1]}}, p} : {{(TW-PW){1'b0}}, p};
  endfunction

  function automatic logic [AW-1:0] sum_ext(input logic [TW-1:0] s,
                                            input logic          sgn);
    return sgn ? {{BW{s[TW-1]}}, s} : {{BW{1'b0}}, s};
  endfunction

  logic              stall_s;
  logic [N*PW-1:0]   s1_prod_d, s1_prod_q;
  logic              s1_valid_q, s1_last_q, s1_signed_q;
  logic [TW-1:0]     s2_sum_d, s2_sum_q;
  logic              s2_valid_q, s2_last_q, s2_signed_q;
  state_e            state_d, state_q;
  logic [AW-1:0]     acc_d, acc_q;
  logic [BW-1:0]     cnt_d, cnt_q;
  logic              vec_signed_d, vec_signed_q;
  logic              err_d, err_q;
  logic              out_valid_d, out_valid_q;
  logic [AW-1:0]     out_data_d, out_data_q;
  logic [BW-1:0]     out_beats_d, out_beats_q;
  logic [AW-1:0]     ext_beat_s, ext_vec_s;
  logic              sat_s, mismatch_s;

  assign stall_s        = out_valid_q & ~out_ready_i;
  assign in_ready_o     = ~stall_s;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_beats_o    = out_beats_q;
  assign err_overflow_o = err_q;

  // Stage 1 products, one per lane.
  always_comb begin
    s1_prod_d = {(N*PW){1'b0}};
    for (int k = 0; k < N; k++) begin
      s1_prod_d[k*PW +: PW] = lane_mul(in_a_i[k*DW +: DW], in_b_i[k*DW +: DW], in_signed_i);
    end
  end

  // Stage 1 register: products plus beat sideband.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_signed_q <= 1'b0;
      s1_prod_q   <= {(N*PW){1'b0}};
    end else if (!stall_s) begin
      s1_valid_q  <= in_valid_i;
      s1_last_q   <= in_last_i;
      s1_signed_q <= in_signed_i;
      s1_prod_q   <= s1_prod_d;
    end
  end

  // Stage 2 reduction of the lane products into one beat sum.
  always_comb begin
    s2_sum_d = {TW{1'b0}};
    for (int k = 0; k < N; k++) begin
      s2_sum_d = s2_sum_d + prod_ext(s1_prod_q[k*PW +: PW], s1_signed_q);
    end
  end

  // Stage 2 register: beat sum plus sideband.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_signed_q <= 1'b0;
      s2_sum_q    <= {TW{1'b0}};
    end else if (!stall_s) begin
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_signed_q <= s1_signed_q;
      s2_sum_q    <= s2_sum_d;
    end
  end

  // A vector's first beat fixes its signedness; later beats extend with it.
  assign ext_beat_s = sum_ext(s2_sum_q, s2_signed_q);
  assign ext_vec_s  = sum_ext(s2_sum_q, vec_signed_q);
  assign sat_s      = (cnt_q == CNT_MAX);
  assign mismatch_s = s2_signed_q ^ vec_signed_q;

  // Stage 3 accumulator FSM and output slot next-state.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    vec_signed_d = vec_signed_q;
    err_d        = err_q;
    // A consumed result drops unless replaced below in the same cycle.
    out_valid_d  = out_valid_q & ~out_ready_i;
    out_data_d   = out_data_q;
    out_beats_d  = out_beats_q;
    if (s2_valid_q && !stall_s) begin
      case (state_q)
        S_IDLE: begin
          acc_d        = ext_beat_s;
          cnt_d        = CNT_ONE;
          vec_signed_d = s2_signed_q;
          if (s2_last_q) begin
            out_valid_d = 1'b1;
            out_data_d  = ext_beat_s;
            out_beats_d = CNT_ONE;
            state_d     = S_IDLE;
          end else begin
            state_d     = S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_d = acc_q + ext_vec_s;
          cnt_d = sat_s ? cnt_q : cnt_q + CNT_ONE;
          err_d = err_q | sat_s | mismatch_s;
          if (s2_last_q) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_d;
            out_beats_d = cnt_d;
            state_d     = S_IDLE;
          end else begin
            state_d     = S_ACCUM;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Stage 3 state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= {AW{1'b0}};
      cnt_q        <= {BW{1'b0}};
      vec_signed_q <= 1'b0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {AW{1'b0}};
      out_beats_q  <= {BW{1'b0}};
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      vec_signed_q <= vec_signed_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_beats_q  <= out_beats_d;
    end
  end

endmodule
